maze_controller: RTL

MAZE_CONTROLLER -- requirements
Module: maze_controller

---
 rtl/maze_controller.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/maze_controller.sv
// Maze player controller: frame-paced button moves, ROM wall lookup, exit detect.
// Ports: clk/rst (async, active-high), i_frame_tick, i_up/i_down/i_left/i_right,
//   o_rom_en/o_rom_addr/i_rom_data (maze ROM port B, 1-cycle read latency),
//   o_player_bcol/o_player_brow, o_exit_bcol/o_exit_brow, o_update_bar, o_win,
//   o_moves (accepted-move count, only when MOVE_COUNT_EN is defined, else 0).
module maze_controller #(
  parameter int START_BCOL  = 1,
  parameter int START_BROW  = 1,
  parameter int EXIT_BCOL   = 38,
  parameter int EXIT_BROW   = 28,
  parameter int MOVE_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_tick,
  input  logic        i_up,
  input  logic        i_down,
  input  logic        i_left,
  input  logic        i_right,
  output logic        o_rom_en,
  output logic [10:0] o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic [5:0]  o_player_bcol,
  output logic [5:0]  o_player_brow,
  output logic [5:0]  o_exit_bcol,
  output logic [5:0]  o_exit_brow,
  output logic        o_update_bar,
  output logic        o_win,
  output logic [15:0] o_moves
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_UPDATE,
    S_WIN
  } state_t;

  localparam logic [5:0] ST_COL = 6'(START_BCOL);
  localparam logic [5:0] ST_ROW = 6'(START_BROW);
  localparam logic [5:0] EX_COL = 6'(EXIT_BCOL);
  localparam logic [5:0] EX_ROW = 6'(EXIT_BROW);
  localparam logic [7:0] RELOAD = 8'(MOVE_FRAMES - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  frame_cnt;
  logic [5:0]  pos_col;
  logic [5:0]  pos_row;
  logic [5:0]  tgt_col;
  logic [5:0]  tgt_row;
  logic [5:0]  cand_col;
  logic [5:0]  cand_row;
  logic        cand_ok;
  logic        any_btn;
  logic        accept;
  logic [15:0] rom_q;
  logic        wall;
  logic [5:0]  new_col;
  logic [5:0]  new_row;
  logic        unused_rom_lo;

  assign any_btn = i_up | i_down | i_left | i_right;
  assign accept  = (state == S_IDLE) & i_frame_tick &
                   (frame_cnt == 8'd0) & any_btn;

  // Candidate neighbour; up wins over down over left over right.
  always_comb begin
    cand_col = pos_col;
    cand_row = pos_row;
    cand_ok  = 1'b0;
    priority case (1'b1)
      i_up: begin
        cand_row = pos_row - 6'd1;
        cand_ok  = (pos_row != 6'd0);
      end
      i_down: begin
        cand_row = pos_row + 6'd1;
        cand_ok  = (pos_row != 6'd29);
      end
      i_left: begin
        cand_col = pos_col - 6'd1;
        cand_ok  = (pos_col != 6'd0);
      end
      i_right: begin
        cand_col = pos_col + 6'd1;
        cand_ok  = (pos_col != 6'd39);
      end
      default: ;
    endcase
  end

  // A block whose upper 12 colour bits are all zero is wall.
  assign wall          = (rom_q[15:4] == 12'h000);
  assign unused_rom_lo = ^rom_q[3:0];
  assign new_col       = wall ? pos_col : tgt_col;
  assign new_row       = wall ? pos_row : tgt_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept && cand_ok) state_nx = S_REQ;
      end
      S_REQ:  state_nx = S_WAIT;
      S_WAIT: state_nx = S_UPDATE;
      S_UPDATE: begin
        if (new_col == EX_COL && new_row == EX_ROW)
          state_nx = S_WIN;
        else
          state_nx = S_IDLE;
      end
      S_WIN:   state_nx = S_WIN;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    o_rom_en     = (state == S_REQ);
    o_update_bar = (state == S_UPDATE) & ~wall;
    o_win        = (state == S_WIN);
  end

  // Ticks only count in IDLE; an attempted move (even off-grid) reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 8'd0;
    end else if (state == S_IDLE && i_frame_tick) begin
      if (accept)
        frame_cnt <= RELOAD;
      else if (frame_cnt != 8'd0)
        frame_cnt <= frame_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_col    <= ST_COL;
      tgt_row    <= ST_ROW;
      o_rom_addr <= 11'd0;
    end else if (accept && cand_ok) begin
      tgt_col    <= cand_col;
      tgt_row    <= cand_row;
      o_rom_addr <= {cand_col, cand_row[4:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rom_q <= 16'h0000;
    else if (state == S_WAIT) rom_q <= i_rom_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_col <= ST_COL;
      pos_row <= ST_ROW;
    end else if (state == S_UPDATE && !wall) begin
      pos_col <= tgt_col;
      pos_row <= tgt_row;
    end
  end

`ifdef MOVE_COUNT_EN
  logic [15:0] moves_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      moves_q <= 16'h0000;
    else if (state == S_UPDATE && !wall &&
             moves_q != 16'hFFFF)
      moves_q <= moves_q + 16'd1;
  end

  assign o_moves = moves_q;
`else
  assign o_moves = 16'h0000;
`endif

  assign o_player_bcol = pos_col;
  assign o_player_brow = pos_row;
  assign o_exit_bcol   = EX_COL;
  assign o_exit_brow   = EX_ROW;

endmodule
